// File: rtl/sseg_scan_mux.sv
// Time-multiplexed driver for three common-anode 7-segment digits.
// Each digit gets one slot: a blanking interval, then its glyph held steady from a per-slot snapshot.
module sseg_scan_mux #(
  parameter int REFRESH_DIV  = 4000,
  parameter int BLANK_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [2:0] digit_en,
  output logic [2:0] sseg_en,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] LAST_C  = CW'(REFRESH_DIV - 1);

  if (BLANK_CYCLES < 1 || REFRESH_DIV < BLANK_CYCLES + 2) begin : g_param_check
    $error("sseg_scan_mux: need BLANK_CYCLES >= 1 and REFRESH_DIV >= BLANK_CYCLES+2");
  end

  typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [7:0]    snap_glyph;
  logic          snap_en;

  phase_t        phase;
  logic          slot_end;
  logic          frame_end;
  logic [7:0]    cur_glyph;
  logic          cur_en;
  logic [2:0]    next_sseg_en;
  logic [7:0]    next_sseg;

  // Phase and output selection are decoded from the pre-edge state only.
  always_comb begin
    phase        = (cnt < BLANK_C) ? PH_BLANK : PH_SHOW;
    slot_end     = (cnt == LAST_C);
    frame_end    = slot_end && (idx == 2'd2);
    cur_glyph    = 8'hFF;
    cur_en       = 1'b0;
    next_sseg_en = 3'b111;
    next_sseg    = 8'hFF;
    case (idx)
      2'd0:    begin cur_glyph = digit0; cur_en = digit_en[0]; end
      2'd1:    begin cur_glyph = digit1; cur_en = digit_en[1]; end
      2'd2:    begin cur_glyph = digit2; cur_en = digit_en[2]; end
      default: begin cur_glyph = 8'hFF;  cur_en = 1'b0;        end
    endcase
    if (phase == PH_SHOW && snap_en) begin
      next_sseg_en = ~(3'b001 << idx);
      next_sseg    = snap_glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap_glyph <= 8'hFF;
      snap_en    <= 1'b0;
      sseg_en    <= 3'b111;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Snapshot keeps tracking the input through the blank phase, then freezes for SHOW.
      if (phase == PH_BLANK) begin
        snap_glyph <= cur_glyph;
        snap_en    <= cur_en;
      end
      sseg_en    <= next_sseg_en;
      sseg       <= next_sseg;
      frame_tick <= frame_end;
    end
  end

endmodule
